// File: rtl/alu_mul_seq.sv
// Shift-and-add 16x16 multiplier (low 16 bits) that borrows the shared ALU for each step.
// Optional MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ITER  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out
);

    localparam int unsigned CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [CW-1:0]    count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef MUL_EARLY_EXIT_EN
                    state_nxt = (operand_b == '0) ? DONE : RUN;
`else
                    state_nxt = RUN;
`endif
                end
            end
            RUN: begin
                if (alu_gnt) begin
                    if (count == CW'(ITER - 1)) begin
                        state_nxt = DONE;
                    end
`ifdef MUL_EARLY_EXIT_EN
                    else if ((mplier >> 1) == '0) begin
                        state_nxt = DONE;
                    end
`endif
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        alu_req = 1'b0;
        case (state)
            RUN: begin
                busy    = 1'b1;
                alu_req = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // result is written on the final step so it is already valid while done is high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= operand_a;
                        mplier <= operand_b;
                        acc    <= '0;
                        count  <= '0;
`ifdef MUL_EARLY_EXIT_EN
                        if (operand_b == '0) begin
                            result <= '0;
                        end
`endif
                    end
                end
                RUN: begin
                    if (alu_gnt) begin
                        if (mplier[0]) begin
                            acc <= alu_out;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count + 1'b1;
                        if (state_nxt == DONE) begin
                            result <= mplier[0] ? alu_out : acc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_a  = acc;
    assign alu_b  = mcand;
    assign alu_op = 4'd0;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed self-checking bench for alu_mul_seq; the shared ALU is modelled as a plain adder.
// Early-exit expectations are selected by MUL_EARLY_EXIT_EN.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] operand_a, operand_b;
    logic        busy, done, alu_req, alu_gnt;
    logic [15:0] result, alu_a, alu_b, alu_out;
    logic [3:0]  alu_op;

    int checks = 0;
    int passed = 0;

    alu_mul_seq #(.WIDTH(16), .ITER(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .alu_req   (alu_req),
        .alu_gnt   (alu_gnt),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out)
    );

    always #5 clk = ~clk;

    assign alu_out = (alu_op == 4'd0) ? alu_a + alu_b : 16'hDEAD;

    // Launches one multiply and watches it: edges counts clock edges after the start edge
    // until done is seen (-1 on timeout). moved counts gnt-low RUN cycles where alu_a/alu_b changed.
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input bit stall,
                           input int pulse_at, input logic [15:0] a2, input logic [15:0] b2,
                           output int edges, output logic [15:0] res,
                           output int busy_n, output int req_n, output int moved);
        logic [15:0] pa, pb;
        bit          watch;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        alu_gnt   = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        edges  = -1;
        res    = 16'hxxxx;
        busy_n = 0;
        req_n  = 0;
        moved  = 0;
        watch  = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (watch && (alu_a !== pa || alu_b !== pb)) moved++;
            if (busy) busy_n++;
            if (alu_req) req_n++;
            if (done) begin
                edges = n;
                res   = result;
                break;
            end
            if (n == pulse_at) begin
                start     = 1'b1;
                operand_a = a2;
                operand_b = b2;
            end else begin
                start = 1'b0;
            end
            alu_gnt = stall ? (n % 2 == 1) : 1'b1;
            watch   = alu_req && !alu_gnt;
            pa      = alu_a;
            pb      = alu_b;
            @(posedge clk); #1;
        end
        start   = 1'b0;
        alu_gnt = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        operand_a = 16'h1234;
        operand_b = 16'h5678;
        alu_gnt = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
        checks++; if (alu_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", alu_req); else passed++;
        checks++; if (result !== 16'h0000) $display("FAIL reset_result got=%h exp=0000", result); else passed++;
        checks++; if (alu_a !== 16'h0000 || alu_b !== 16'h0000)
            $display("FAIL reset_alu_ab got=%h/%h exp=0000/0000", alu_a, alu_b); else passed++;
        checks++; if (alu_op !== 4'd0) $display("FAIL reset_alu_op got=%h exp=0", alu_op); else passed++;
    endtask

    task automatic test_basic();
        int e, bn, rn, mv;
        logic [15:0] r;
        run_mul(16'd3, 16'd5, 1'b0, -1, 16'd0, 16'd0, e, r, bn, rn, mv);
        checks++; if (e !== 16) $display("FAIL basic_latency got=%0d exp=16", e); else passed++;
        checks++; if (r !== 16'h000F) $display("FAIL basic_result got=%h exp=000f", r); else passed++;
        checks++; if (bn !== 17) $display("FAIL basic_busy_cycles got=%0d exp=17", bn); else passed++;
        checks++; if (rn !== 16) $display("FAIL basic_req_cycles got=%0d exp=16", rn); else passed++;
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL basic_idle_after got=%b%b exp=00", done, busy); else passed++;
        checks++; if (result !== 16'h000F) $display("FAIL basic_result_held got=%h exp=000f", result); else passed++;
    endtask

    task automatic test_truncation();
        int e, bn, rn, mv;
        logic [15:0] r;
        run_mul(16'hFFFF, 16'hFFFF, 1'b0, -1, 16'd0, 16'd0, e, r, bn, rn, mv);
        checks++; if (r !== 16'h0001) $display("FAIL trunc_ffff got=%h exp=0001", r); else passed++;
        checks++; if (e !== 16) $display("FAIL trunc_ffff_latency got=%0d exp=16", e); else passed++;
        @(posedge clk); #1;
        run_mul(16'h0100, 16'h0100, 1'b0, -1, 16'd0, 16'd0, e, r, bn, rn, mv);
        checks++; if (r !== 16'h0000) $display("FAIL trunc_0100 got=%h exp=0000", r); else passed++;
        checks++; if (e !== 16) $display("FAIL trunc_0100_latency got=%0d exp=16", e); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        int e, bn, rn, mv;
        logic [15:0] r;
        run_mul(16'd7, 16'd9, 1'b1, -1, 16'd0, 16'd0, e, r, bn, rn, mv);
        checks++; if (e !== 32) $display("FAIL stall_latency got=%0d exp=32", e); else passed++;
        checks++; if (r !== 16'h003F) $display("FAIL stall_result got=%h exp=003f", r); else passed++;
        checks++; if (mv !== 0) $display("FAIL stall_regs_moved got=%0d exp=0", mv); else passed++;
        checks++; if (rn !== 32) $display("FAIL stall_req_cycles got=%0d exp=32", rn); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_restart_ignored();
        int e, bn, rn, mv;
        logic [15:0] r;
        run_mul(16'd3, 16'd5, 1'b0, 5, 16'd9, 16'd9, e, r, bn, rn, mv);
        checks++; if (r !== 16'h000F) $display("FAIL restart_result got=%h exp=000f", r); else passed++;
        checks++; if (e !== 16) $display("FAIL restart_latency got=%0d exp=16", e); else passed++;
        @(posedge clk); #1;
        run_mul(16'd9, 16'd9, 1'b0, -1, 16'd0, 16'd0, e, r, bn, rn, mv);
        checks++; if (r !== 16'h0051) $display("FAIL restart_next got=%h exp=0051", r); else passed++;
        checks++; if (e !== 16) $display("FAIL restart_next_latency got=%0d exp=16", e); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun();
        int e, bn, rn, mv, dn;
        logic [15:0] r;
        operand_a = 16'd3;
        operand_b = 16'd5;
        start     = 1'b1;
        alu_gnt   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else passed++;
        checks++; if (alu_req !== 1'b0) $display("FAIL midrst_req got=%b exp=0", alu_req); else passed++;
        checks++; if (result !== 16'h0000) $display("FAIL midrst_result got=%h exp=0000", result); else passed++;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dn++;
            @(posedge clk); #1;
        end
        checks++; if (dn !== 0) $display("FAIL midrst_no_done got=%0d exp=0", dn); else passed++;
        run_mul(16'd2, 16'd3, 1'b0, -1, 16'd0, 16'd0, e, r, bn, rn, mv);
        checks++; if (r !== 16'h0006) $display("FAIL midrst_next got=%h exp=0006", r); else passed++;
        checks++; if (e !== 16) $display("FAIL midrst_next_latency got=%0d exp=16", e); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int          d1, d2;
        logic [15:0] r1, r2;
        d1 = -1;
        d2 = -1;
        r1 = 16'hxxxx;
        r2 = 16'hxxxx;
        operand_a = 16'd3;
        operand_b = 16'd4;
        start     = 1'b1;
        alu_gnt   = 1'b1;
        @(posedge clk); #1;
        operand_a = 16'd5;
        operand_b = 16'd6;
        for (int n = 0; n < 100; n++) begin
            if (done) begin
                if (d1 < 0) begin
                    d1 = n;
                    r1 = result;
                end else begin
                    d2 = n;
                    r2 = result;
                    break;
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++; if (d1 !== 16 || r1 !== 16'h000C)
            $display("FAIL b2b_first got=%0d/%h exp=16/000c", d1, r1); else passed++;
        checks++; if (d2 !== 34) $display("FAIL b2b_second_latency got=%0d exp=34", d2); else passed++;
        checks++; if (r2 !== 16'h001E) $display("FAIL b2b_second_result got=%h exp=001e", r2); else passed++;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_early_exit();
        int e, bn, rn, mv;
        logic [15:0] r;
        run_mul(16'd7, 16'd2, 1'b0, -1, 16'd0, 16'd0, e, r, bn, rn, mv);
        checks++; if (r !== 16'h000E) $display("FAIL ee_7x2_result got=%h exp=000e", r); else passed++;
`ifdef MUL_EARLY_EXIT_EN
        checks++; if (e !== 2) $display("FAIL ee_7x2_latency got=%0d exp=2", e); else passed++;
        checks++; if (rn !== 2) $display("FAIL ee_7x2_req got=%0d exp=2", rn); else passed++;
`else
        checks++; if (e !== 16) $display("FAIL ee_7x2_latency got=%0d exp=16", e); else passed++;
        checks++; if (rn !== 16) $display("FAIL ee_7x2_req got=%0d exp=16", rn); else passed++;
`endif
        @(posedge clk); #1;
        run_mul(16'd7, 16'd0, 1'b0, -1, 16'd0, 16'd0, e, r, bn, rn, mv);
        checks++; if (r !== 16'h0000) $display("FAIL ee_zero_result got=%h exp=0000", r); else passed++;
`ifdef MUL_EARLY_EXIT_EN
        checks++; if (e !== 0) $display("FAIL ee_zero_latency got=%0d exp=0", e); else passed++;
        checks++; if (rn !== 0) $display("FAIL ee_zero_req got=%0d exp=0", rn); else passed++;
`else
        checks++; if (e !== 16) $display("FAIL ee_zero_latency got=%0d exp=16", e); else passed++;
        checks++; if (rn !== 16) $display("FAIL ee_zero_req got=%0d exp=16", rn); else passed++;
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_truncation();
        test_stall();
        test_restart_ignored();
        test_reset_midrun();
        test_back_to_back();
        test_early_exit();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
